// File: rtl/bht_ctrl_pkg.sv
// Shared definitions for the branch history table controller:
// PC width, 2-bit counter encodings, FSM states and counter update helper.
package bht_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } bht_cnt_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bht_state_e;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] bht_next(input logic [1:0] cnt,
                                            input logic       taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != BHT_ST)
            res = cnt + 2'd1;
        else if (!taken && cnt != BHT_SNT)
            res = cnt - 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Training-update FIFO: stores {table index, taken} per resolved branch.
// Ports: clk, rst (async low), rdy (freeze), push/pop, full/empty, head out.
module bht_upd_fifo
    import bht_ctrl_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             push_taken,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [IDX_W-1:0] head_idx,
    output logic             head_taken
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] mem_idx   [DEPTH];
    logic             mem_taken [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = rdy && push && !full;
    assign do_pop     = rdy && pop && !empty;
    assign head_idx   = mem_idx[rd_ptr];
    assign head_taken = mem_taken[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_idx[wr_ptr]   <= push_idx;
            mem_taken[wr_ptr] <= push_taken;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bht_ctrl.sv
// BHT controller: owns the 2-bit counter table, serves fetch lookups,
// drains ROB training updates from a FIFO with anti-starvation arbitration.
// Ports: clk, rst (async low), rdy, lookup_*, pred_*, upd_*, init_done.
module bht_ctrl
    import bht_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_WIDTH,
    parameter int IDX_W      = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              lookup_ready,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    output logic              upd_ready,
    output logic              init_done
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int SC_W    = $clog2(STARVE_LIM + 1);

    bht_state_e       state;
    bht_state_e       state_nxt;
    logic [IDX_W-1:0] init_idx;
    logic [SC_W-1:0]  starve_cnt;
    logic [1:0]       tbl [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic             full;
    logic             empty;
    logic             force_drain;
    logic             lk_acc;
    logic             drain;
    logic             init_last;
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_waddr;
    logic [1:0]       tbl_wdata;
    logic             unused_pc_bits;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{lookup_pc[ADDR_W-1:IDX_W+2], lookup_pc[1:0],
                              upd_pc[ADDR_W-1:IDX_W+2], upd_pc[1:0]};

    // A lookup owns the table unless the FIFO has waited too long.
    assign force_drain  = (starve_cnt == SC_W'(STARVE_LIM)) && !empty;
    assign lookup_ready = rdy && (state == RUN) && !force_drain;
    assign lk_acc       = lookup_valid && lookup_ready;
    assign drain        = rdy && (state == RUN) && !empty && !lk_acc;
    assign upd_ready    = rdy && rst && !full;
    assign init_last    = (init_idx == '1);

    bht_upd_fifo #(
        .IDX_W (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .push       (upd_valid && upd_ready),
        .push_idx   (up_idx),
        .push_taken (upd_taken),
        .pop        (drain),
        .full       (full),
        .empty      (empty),
        .head_idx   (head_idx),
        .head_taken (head_taken)
    );

    always_comb begin
        state_nxt = state;
        tbl_we    = 1'b0;
        tbl_waddr = init_idx;
        tbl_wdata = BHT_WNT;
        unique case (state)
            INIT: begin
                if (rdy) begin
                    tbl_we = 1'b1;
                    if (init_last)
                        state_nxt = RUN;
                end
            end
            RUN: begin
                if (drain) begin
                    tbl_we    = 1'b1;
                    tbl_waddr = head_idx;
                    tbl_wdata = bht_next(tbl[head_idx], head_taken);
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    // Table contents are established by the INIT sweep, not by reset.
    always_ff @(posedge clk) begin
        if (tbl_we)
            tbl[tbl_waddr] <= tbl_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= INIT;
            init_idx   <= '0;
            init_done  <= 1'b0;
            starve_cnt <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else if (rdy) begin
            state      <= state_nxt;
            pred_valid <= lk_acc;
            if (lk_acc)
                pred_taken <= tbl[lk_idx][1];
            if (state == INIT) begin
                init_idx <= init_idx + IDX_W'(1);
                if (init_last)
                    init_done <= 1'b1;
            end
            if (drain || empty)
                starve_cnt <= '0;
            else if (lk_acc)
                starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

endmodule

// File: tb/tb_bht_ctrl.sv
// Self-checking bench for bht_ctrl: table-driven lookup/update vectors
// plus hand-written sequences for init, starvation, full FIFO and reset.
module tb_bht_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        lookup_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic        upd_ready;
    logic        init_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bht_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .lookup_ready (lookup_ready),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_ready    (upd_ready),
        .init_done    (init_done)
    );

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        exp_pv;
        logic        exp_pt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; comb outputs sampled mid-cycle.
    task automatic cyc(input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic [31:0] upc,
                       input logic ut, output logic lr, output logic ur);
        lookup_valid = lv;
        lookup_pc    = lpc;
        upd_valid    = uv;
        upd_pc       = upc;
        upd_taken    = ut;
        #1;
        lr = lookup_ready;
        ur = upd_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int n);
        logic lr, ur;
        n = 0;
        while (!init_done && n < 300) begin
            cyc(0, 0, 0, 0, 0, lr, ur);
            n++;
        end
    endtask

    task automatic lookup(input logic [31:0] pc, output logic pt);
        logic lr, ur;
        cyc(1, pc, 0, 0, 0, lr, ur);
        pt = pred_taken;
        if (!lr || !pred_valid)
            pt = 1'bx;
    endtask

    vec_t tv [15];

    initial begin
        logic lr, ur, pt;
        int   n, refused;
        logic [19:0] lr_vec, lr_exp;

        // ---------------- reset and init timing ----------------
        #1;
        @(posedge clk);
        #1;
        chk("rst_pred_valid", {31'b0, pred_valid}, 0);
        chk("rst_pred_taken", {31'b0, pred_taken}, 0);
        chk("rst_init_done", {31'b0, init_done}, 0);
        chk("rst_lookup_ready", {31'b0, lookup_ready}, 0);
        chk("rst_upd_ready", {31'b0, upd_ready}, 0);
        rst = 1'b1;
        cyc(1, 32'h1000, 0, 0, 0, lr, ur);
        chk("init_lookup_ready", {31'b0, lr}, 0);
        n = 1;
        while (!init_done && n < 300) begin
            cyc(0, 0, 0, 0, 0, lr, ur);
            n++;
        end
        chk("init_cycles", n, 64);
        cyc(1, 32'h0000_1000, 0, 0, 0, lr, ur);
        chk("first_lookup_ready", {31'b0, lr}, 1);
        chk("first_pred_valid", {31'b0, pred_valid}, 1);
        chk("first_pred_taken", {31'b0, pred_taken}, 0);

        // ---------------- training vectors ----------------
        tv[0]  = '{0, 0, 1, 32'h100, 1, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 0};
        tv[2]  = '{1, 32'h100, 0, 0, 0, 1, 1};
        tv[3]  = '{0, 0, 1, 32'h100, 1, 0, 1};
        tv[4]  = '{0, 0, 1, 32'h100, 1, 0, 1};
        tv[5]  = '{0, 0, 1, 32'h100, 1, 0, 1};
        tv[6]  = '{0, 0, 1, 32'h100, 0, 0, 1};
        tv[7]  = '{0, 0, 0, 0, 0, 0, 1};
        tv[8]  = '{0, 0, 0, 0, 0, 0, 1};
        tv[9]  = '{1, 32'h100, 0, 0, 0, 1, 1};
        tv[10] = '{1, 32'h104, 0, 0, 0, 1, 0};
        tv[11] = '{1, 32'h200, 0, 0, 0, 1, 1};
        tv[12] = '{0, 0, 1, 32'h200, 0, 0, 1};
        tv[13] = '{0, 0, 0, 0, 0, 0, 1};
        tv[14] = '{1, 32'h100, 0, 0, 0, 1, 0};
        for (int i = 0; i < 15; i++) begin
            cyc(tv[i].lv, tv[i].lpc, tv[i].uv, tv[i].upc, tv[i].ut,
                lr, ur);
            chk($sformatf("vec%0d_pv", i), {31'b0, pred_valid},
                {31'b0, tv[i].exp_pv});
            chk($sformatf("vec%0d_pt", i), {31'b0, pred_taken},
                {31'b0, tv[i].exp_pt});
        end

        // ---------------- full FIFO under constant lookups ----------------
        cyc(1, 32'h2000, 1, 32'h14, 1, lr, ur);
        cyc(1, 32'h2000, 1, 32'h14, 1, lr, ur);
        cyc(1, 32'h2000, 1, 32'h18, 0, lr, ur);
        cyc(1, 32'h2000, 1, 32'h18, 1, lr, ur);
        chk("fill_ur", {31'b0, ur}, 1);
        refused = 0;
        cyc(1, 32'h2000, 1, 32'h1C, 1, lr, ur);
        chk("full_refuse", {31'b0, ur}, 0);
        while (!ur && refused < 30) begin
            refused++;
            cyc(1, 32'h2000, 1, 32'h1C, 1, lr, ur);
            if (!ur) lr_vec[0] = lr;
        end
        chk("full_refused_cycles", refused, 6);
        chk("forced_drain_lr", {31'b0, lr_vec[0]}, 0);
        chk("accept_lr", {31'b0, lr}, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, lr, ur);
        lookup(32'h14, pt);
        chk("fifo_idx5", {31'b0, pt}, 1);
        lookup(32'h18, pt);
        chk("fifo_idx6", {31'b0, pt}, 0);
        lookup(32'h1C, pt);
        chk("fifo_idx7_late_push", {31'b0, pt}, 1);

        // ---------------- starvation pattern ----------------
        cyc(0, 0, 0, 0, 0, lr, ur);
        cyc(1, 32'h3000, 1, 32'h28, 1, lr, ur);
        lr_exp = '1;
        lr_exp[8] = 1'b0;
        lr_exp[17] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'h3000, i == 0, 32'h2C, 1, lr, ur);
            lr_vec[i] = lr;
        end
        chk("starve_pattern", {12'b0, lr_vec}, {12'b0, lr_exp});
        lookup(32'h28, pt);
        chk("starve_idx10", {31'b0, pt}, 1);
        lookup(32'h2C, pt);
        chk("starve_idx11", {31'b0, pt}, 1);

        // ---------------- async reset mid-run ----------------
        for (int i = 0; i < 3; i++)
            cyc(1, 32'h28, 1, 32'h24, 1, lr, ur);
        chk("pre_rst_pv", {31'b0, pred_valid}, 1);
        chk("pre_rst_pt", {31'b0, pred_taken}, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pred_valid", {31'b0, pred_valid}, 0);
        chk("arst_pred_taken", {31'b0, pred_taken}, 0);
        chk("arst_init_done", {31'b0, init_done}, 0);
        chk("arst_upd_ready", {31'b0, upd_ready}, 0);
        lookup_valid = 1'b0;
        upd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_init(n);
        chk("reinit_cycles", n, 64);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, lr, ur);
        for (int i = 0; i < 64; i++) begin
            lookup(i << 2, pt);
            chk($sformatf("readback%0d", i), {31'b0, pt}, 0);
        end

        // ---------------- rdy stalls ----------------
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0, lr, ur);
            n++;
        end
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 1, 32'h30, 1, lr, ur);
            n++;
            if (i == 0) begin
                chk("stall_ur", {31'b0, ur}, 0);
                chk("stall_lr", {31'b0, lr}, 0);
            end
        end
        chk("stall_init_done", {31'b0, init_done}, 0);
        rdy = 1'b1;
        while (!init_done && n < 300) begin
            cyc(0, 0, 0, 0, 0, lr, ur);
            n++;
        end
        chk("stall_init_cycles", n, 74);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, lr, ur);
        lookup(32'h30, pt);
        chk("stall_no_push", {31'b0, pt}, 0);
        rdy = 1'b0;
        cyc(1, 32'h30, 0, 0, 0, lr, ur);
        chk("stall_hold_lr", {31'b0, lr}, 0);
        chk("stall_hold_pv", {31'b0, pred_valid}, 1);
        rdy = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bht_ctrl.md
Name: bht_ctrl

Overview:
Branch history table controller that owns the 2-bit saturating-counter table behind the fetch-stage predictor. It serves per-cycle lookups from the instruction fetcher and buffers training updates from the ROB in a small FIFO. One table access is allowed per cycle; the block arbitrates that access between lookups and update drains, with an anti-starvation rule. After reset it runs a table-initialisation sequence before accepting lookups.

Parameters:
ADDR_W, 32, PC width.
IDX_W, 6, table index width; 2^IDX_W entries, index = pc[IDX_W+1:2].
FIFO_DEPTH, 4, update FIFO entries (power of 2).
STARVE_LIM, 8, consecutive lookup-won cycles with a pending update before a drain is forced.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
rdy  in  1  global ready; 0 freezes all state.
lookup_valid  in  1  fetcher requests a prediction.
lookup_pc  in  ADDR_W  PC of the instruction being predicted.
lookup_ready  out  1  lookup accepted this cycle (combinational).
pred_valid  out  1  registered; prediction available.
pred_taken  out  1  registered; counter[1] of the looked-up entry.
upd_valid  in  1  ROB commits a resolved branch.
upd_pc  in  ADDR_W  PC of the resolved branch.
upd_taken  in  1  actual branch outcome.
upd_ready  out  1  FIFO can accept an update (combinational).
init_done  out  1  registered; table initialised.

Behaviour:
- Reset (rst=0, async): FSM=INIT, init_idx=0, FIFO empty, starve_cnt=0. pred_valid=0, pred_taken=0, init_done=0. lookup_ready=0 and upd_ready=0 while in reset.
- rdy=0: no register, table or FIFO changes; lookup_ready=0, upd_ready=0; registered outputs hold their values.
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- INIT state:
  - Each rdy cycle writes table[init_idx]=01, then init_idx++.
  - After writing entry 2^IDX_W-1, go to RUN and set init_done=1 on the same edge.
  - Init takes exactly 2^IDX_W rdy cycles.
  - lookup_ready=0 in INIT. upd_ready=rdy && !full, so updates may queue during INIT but do not drain.
- RUN state, per rdy cycle; exactly one of {lookup, drain, idle} uses the table:
  - force_drain = (starve_cnt==STARVE_LIM) && !empty.
  - lookup_ready = rdy && RUN && !force_drain.
  - Lookup accepted (lookup_valid && lookup_ready): next edge pred_valid=1, pred_taken=table[idx(lookup_pc)][1]. Latency is 1 cycle.
  - No lookup accepted: pred_valid<=0 on that edge. pred_taken holds.
  - Drain occurs when !empty and no lookup is accepted. Pop the head and read-modify-write its entry: taken increments and saturates at 11; not-taken decrements and saturates at 00.
  - A drain write at edge N is visible to a lookup accepted in cycle N+1. Updates still in the FIFO are not reflected in predictions; no bypass.
  - starve_cnt: increments when a lookup is accepted with FIFO non-empty; resets to 0 on any drain or when the FIFO is empty.
- FIFO:
  - upd_ready depends only on the full flag. Push and pop in the same cycle are allowed when not full.
  - When full, a push is refused even if a pop happens that cycle.
  - Pointers wrap modulo FIFO_DEPTH; count is (log2 FIFO_DEPTH)+1 bits.
- Aliasing: PCs with equal pc[IDX_W+1:2] share an entry; no tags.
- Reset mid-operation discards queued updates and re-runs INIT.

Decomposition:
- Shared define package: ADDR_WIDTH, BHT counter encodings (BHT_SNT/WNT/WT/ST), FSM state codes (INIT/RUN).
- One sub-module, bht_upd_fifo: synchronous FIFO with push/pop/full/empty and head outputs {pc index, taken}. Only the index bits are stored, not the full PC.
- Table, arbitration, starvation counter and init FSM live in bht_ctrl.

Test Plan:
1. Release rst with rdy=1 → init_done rises exactly 64 cycles later. Then lookup pc=0x0000_1000 → pred_valid=1, pred_taken=0 the next cycle.
2. Push {0x100, taken} and idle one cycle, then lookup 0x100 → pred_taken=1. Push 3 more taken plus 1 not-taken, drain, then lookup 0x100 → pred_taken=1 (counter 10). Lookup 0x200 (aliases to index 0) → pred_taken=1.
3. Hold lookup_valid=1 and push 5 updates back-to-back → upd_ready=0 on the 5th push cycle. It rises only after the forced drain cycle; no update is lost (verify final counters).
4. Starvation: FIFO holds 2 entries and lookup_valid=1 for 20 cycles → lookups accepted in cycles 0-7, lookup_ready=0 in cycle 8 (drain), accepted in 9-16, lookup_ready=0 in cycle 17, FIFO empty afterwards.
5. Drop rdy for 10 cycles during INIT → init_done asserts at cycle 74 instead of 64. No FIFO or output changes while rdy=0.
6. Assert rst mid-RUN with 3 queued updates → outputs go to 0 immediately (async). After release: FIFO empty, INIT repeats, all entries read back as not-taken.
